// File: rtl/raytracing_scheduler.sv
// Frame sequencer for the raytracing worker array: per row, precompute y operands,
// then launch/wait/drain each batch of N_WORKERS*JOBS_SUBDIVISION pixels to the framebuffer.
package Types;
  localparam int COLOR_W = 8;
  typedef logic [COLOR_W-1:0] Color;
  typedef struct packed {
    logic signed [13:0] x;
    logic signed [13:0] y;
    logic signed [13:0] z;
    logic        [13:0] radius;
    Color               color;
  } Sphere;
endpackage

module raytracing_scheduler #(
  parameter int N_WORKERS        = 4,
  parameter int JOBS_SUBDIVISION = 8,
  parameter int SCREEN_W         = 320,
  parameter int SCREEN_H         = 240,
  parameter int COLOR_W          = 8,
  parameter int ADDR_W           = 17
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         frame_start,
  input  Types::Sphere                                 sphere_in,
  output logic                                         frame_busy,
  output logic                                         frame_done,
  output logic [N_WORKERS-1:0]                         worker_activate,
  output logic [N_WORKERS*12-1:0]                      worker_start_x,
  output Types::Sphere                                 sphere_out,
  output logic signed [21:0]                           doty_r,
  output logic [15:0]                                  pixely_sr,
  output logic [26:0]                                  originy_sr,
  input  logic [N_WORKERS-1:0]                         worker_busy,
  input  logic [N_WORKERS*JOBS_SUBDIVISION*COLOR_W-1:0] worker_buffer,
  output logic                                         fb_wr_en,
  output logic [ADDR_W-1:0]                            fb_addr,
  output logic [COLOR_W-1:0]                           fb_data,
  input  logic                                         fb_ready
);

  localparam int B     = N_WORKERS * JOBS_SUBDIVISION;
  localparam int NB    = SCREEN_W / B;
  localparam int ROW_W = $clog2(SCREEN_H + 1);
  localparam int BAT_W = $clog2(NB + 1);
  localparam int PIX_W = $clog2(B + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW_SETUP, S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE, S_DRAIN, S_GAP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [BAT_W-1:0]   batch_q, batch_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  Types::Sphere       sphere_q, sphere_d;
  logic signed [21:0] doty_q, doty_d;
  logic [15:0]        pixely_q, pixely_d;
  logic [26:0]        originy_q, originy_d;

  logic signed [11:0] y_c;
  logic signed [25:0] doty_full;
  logic signed [23:0] pixely_full;
  logic signed [27:0] originy_full;
  logic               last_pix, last_batch, last_row;

  // Full-precision signed products, truncated to the operand port widths.
  assign y_c          = $signed(12'(row_q)) - 12'(SCREEN_H / 2);
  assign doty_full    = 26'(y_c) * 26'(sphere_q.y);
  assign pixely_full  = 24'(y_c) * 24'(y_c);
  assign originy_full = 28'(sphere_q.y) * 28'(sphere_q.y);

  assign last_pix   = (pix_q == PIX_W'(B - 1));
  assign last_batch = (batch_q == BAT_W'(NB - 1));
  assign last_row   = (row_q == ROW_W'(SCREEN_H - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      batch_q   <= '0;
      pix_q     <= '0;
      sphere_q  <= '0;
      doty_q    <= '0;
      pixely_q  <= '0;
      originy_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      batch_q   <= batch_d;
      pix_q     <= pix_d;
      sphere_q  <= sphere_d;
      doty_q    <= doty_d;
      pixely_q  <= pixely_d;
      originy_q <= originy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    batch_d   = batch_q;
    pix_d     = pix_q;
    sphere_d  = sphere_q;
    doty_d    = doty_q;
    pixely_d  = pixely_q;
    originy_d = originy_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          sphere_d = sphere_in;
          row_d    = '0;
          state_d  = S_ROW_SETUP;
        end
      end
      S_ROW_SETUP: begin
        doty_d    = doty_full[21:0];
        pixely_d  = pixely_full[15:0];
        originy_d = originy_full[26:0];
        batch_d   = '0;
        state_d   = S_LAUNCH;
      end
      S_LAUNCH: state_d = S_WAIT_ACK;
      // Waiting for all-busy first keeps the pre-busy cycle from reading as done.
      S_WAIT_ACK: begin
        if (&worker_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (worker_busy == '0) begin
          pix_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fb_ready) begin
          if (last_pix) state_d = S_GAP;
          else          pix_d   = pix_q + 1'b1;
        end
      end
      S_GAP: begin
        if (!last_batch) begin
          batch_d = batch_q + 1'b1;
          state_d = S_LAUNCH;
        end else if (!last_row) begin
          row_d   = row_q + 1'b1;
          state_d = S_ROW_SETUP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    worker_activate = '0;
    worker_start_x  = '0;
    fb_wr_en        = 1'b0;
    fb_addr         = '0;
    fb_data         = '0;
    frame_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    frame_done      = (state_q == S_DONE);
    if (state_q inside {S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE, S_DRAIN}) begin
      worker_activate = '1;
      for (int unsigned w = 0; w < N_WORKERS; w++) begin
        worker_start_x[w*12 +: 12] = 12'(batch_q) * 12'(B) + 12'(w) - 12'(SCREEN_W / 2);
      end
    end
    if (state_q == S_DRAIN) begin
      fb_wr_en = 1'b1;
      fb_addr  = ADDR_W'(row_q) * ADDR_W'(SCREEN_W) + ADDR_W'(batch_q) * ADDR_W'(B)
               + ADDR_W'(pix_q);
      // Pixel p lives in worker p mod N, job slot p / N.
      for (int unsigned p = 0; p < B; p++) begin
        if (pix_q == PIX_W'(p)) begin
          fb_data = worker_buffer[((p % N_WORKERS) * JOBS_SUBDIVISION + p / N_WORKERS) * COLOR_W
                                  +: COLOR_W];
        end
      end
    end
  end

  assign sphere_out = sphere_q;
  assign doty_r     = doty_q;
  assign pixely_sr  = pixely_q;
  assign originy_sr = originy_q;

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Directed bench for raytracing_scheduler on a 8x2 screen with 2 workers x 2 jobs.
module tb_raytracing_scheduler;

  localparam int N  = 2;
  localparam int J  = 2;
  localparam int CW = 8;
  localparam int AW = 17;
  localparam int LIMIT = 3000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 frame_start;
  Types::Sphere         sphere_in;
  logic                 frame_busy, frame_done;
  logic [N-1:0]         worker_activate;
  logic [N*12-1:0]      worker_start_x;
  Types::Sphere         sphere_out;
  logic signed [21:0]   doty_r;
  logic [15:0]          pixely_sr;
  logic [26:0]          originy_sr;
  logic [N-1:0]         worker_busy;
  logic [N*J*CW-1:0]    worker_buffer;
  logic                 fb_wr_en;
  logic [AW-1:0]        fb_addr;
  logic [CW-1:0]        fb_data;
  logic                 fb_ready;

  int   n_total = 0;
  int   n_bad   = 0;
  int   ack_dly = 0;
  bit   ready_tog = 1'b0;
  logic tog_q;
  int   wcnt;

  Types::Sphere sph, other;
  logic [7:0]   pix_exp [4];

  raytracing_scheduler #(
    .N_WORKERS(N), .JOBS_SUBDIVISION(J), .SCREEN_W(8), .SCREEN_H(2),
    .COLOR_W(CW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .sphere_in(sphere_in),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .worker_activate(worker_activate), .worker_start_x(worker_start_x),
    .sphere_out(sphere_out), .doty_r(doty_r), .pixely_sr(pixely_sr),
    .originy_sr(originy_sr), .worker_busy(worker_busy),
    .worker_buffer(worker_buffer), .fb_wr_en(fb_wr_en), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  // Worker stand-in: busy for 5 cycles, starting ack_dly cycles after activate is seen.
  always @(posedge clk or posedge rst) begin
    if (rst)                     wcnt <= 0;
    else if (!worker_activate[0]) wcnt <= 0;
    else if (wcnt < 1000)        wcnt <= wcnt + 1;
  end
  assign worker_busy = (wcnt >= ack_dly + 1 && wcnt <= ack_dly + 5) ? '1 : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) tog_q <= 1'b1;
    else     tog_q <= ~tog_q;
  end
  assign fb_ready = ready_tog ? tog_q : 1'b1;

  // buffer[w][j] = 16*w + j, job 0 in the LSBs of each worker slice
  assign worker_buffer = 32'h11_10_01_00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input string name, input bit tog, input int dly,
                           input bit mid_pulse, input bit ops, input int abort_at);
    int n_acc = 0, done_cnt = 0, busy_low = 0, early = 0, cyc = 0;
    int lowrun = 0, ngaps = 0, done_after = 0, busy_after = 0;
    int gaps [4];
    bit seen_hi = 1'b0;
    ready_tog = tog;
    ack_dly   = dly;
    @(negedge clk);
    sphere_in   = sph;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    sphere_in   = other;
    while (done_cnt == 0 && cyc < LIMIT) begin
      if (frame_done) done_cnt++;
      else if (!frame_busy) busy_low++;
      if (fb_wr_en) begin
        check({name, "_addr"}, 64'(fb_addr), 64'(n_acc));
        check({name, "_data"}, 64'(fb_data), 64'(pix_exp[n_acc % 4]));
        if (wcnt < dly + 6) early++;
        if (fb_ready) begin
          if (ops && n_acc == 0) begin
            check({name, "_doty_r0"},    64'(doty_r),     64'd3);
            check({name, "_pixely_r0"},  64'(pixely_sr),  64'd1);
            check({name, "_originy_r0"}, 64'(originy_sr), 64'd9);
            check({name, "_sphere"},     64'(sphere_out), 64'(sph));
          end
          if (ops && n_acc == 4)
            check({name, "_startx_b1"}, 64'(worker_start_x), {40'd0, 12'sd1, 12'sd0});
          if (ops && n_acc == 8) begin
            check({name, "_doty_r1"},   64'(doty_r),    64'd0);
            check({name, "_pixely_r1"}, 64'(pixely_sr), 64'd0);
          end
          n_acc++;
        end
      end
      if (worker_activate[0]) begin
        if (seen_hi && lowrun > 0) begin
          if (ngaps < 4) gaps[ngaps] = lowrun;
          ngaps++;
        end
        seen_hi = 1'b1;
        lowrun  = 0;
      end else if (seen_hi) begin
        lowrun++;
      end
      if (abort_at > 0 && fb_wr_en && n_acc == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check({name, "_rst_ctl"}, 64'({fb_wr_en, worker_activate, frame_busy, frame_done}), 64'd0);
        check({name, "_rst_ops"}, 64'({doty_r, pixely_sr, originy_sr}), 64'd0);
        check({name, "_rst_fb"},  64'({worker_start_x, fb_addr, fb_data}), 64'd0);
        check({name, "_rst_sph"}, 64'(sphere_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      // a start while busy and a start on the DONE cycle must both be ignored
      frame_start = (mid_pulse && cyc == 10) || frame_done;
      if (done_cnt == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_timeout"}, 64'(cyc < LIMIT), 64'd1);
    check({name, "_nwrites"}, 64'(n_acc), 64'd16);
    check({name, "_busy_gap"}, 64'(busy_low), 64'd0);
    check({name, "_early_drain"}, 64'(early), 64'd0);
    if (ops) begin
      check({name, "_ngaps"}, 64'(ngaps), 64'd3);
      check({name, "_gap0"}, 64'(gaps[0]), 64'd1);
      check({name, "_gap1"}, 64'(gaps[1]), 64'd2);
      check({name, "_gap2"}, 64'(gaps[2]), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (frame_done) done_after++;
      if (frame_busy) busy_after++;
    end
    check({name, "_done_once"}, 64'(done_after), 64'd0);
    check({name, "_idle_after"}, 64'(busy_after), 64'd0);
  endtask

  initial begin
    pix_exp[0] = 8'd0;
    pix_exp[1] = 8'd16;
    pix_exp[2] = 8'd1;
    pix_exp[3] = 8'd17;
    sph   = '{x: 14'sd5, y: -14'sd3, z: 14'sd100, radius: 14'd20, color: 8'hAB};
    other = '{x: 14'sd9, y: 14'sd7, z: 14'sd50, radius: 14'd4, color: 8'h12};
    rst         = 1'b1;
    frame_start = 1'b0;
    sphere_in   = other;
    @(negedge clk);
    check("reset_ctl", 64'({fb_wr_en, worker_activate, frame_busy, frame_done}), 64'd0);
    check("reset_ops", 64'({doty_r, pixely_sr, originy_sr}), 64'd0);
    check("reset_fb",  64'({worker_start_x, fb_addr, fb_data}), 64'd0);
    check("reset_sph", 64'(sphere_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_frame("basic",   1'b0, 0, 1'b0, 1'b1, 0);
    run_frame("toggle",  1'b1, 0, 1'b0, 1'b0, 0);
    run_frame("ackdly",  1'b0, 3, 1'b0, 1'b1, 0);
    run_frame("abort",   1'b0, 0, 1'b0, 1'b0, 5);
    run_frame("restart", 1'b0, 0, 1'b1, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/raytracing_scheduler.md
Name: raytracing_scheduler

Overview:
Frame-level sequencer for the Raytracing_Worker array. Walks the screen row by row and, within each row, batch by batch. Per row it precomputes the y-dependent operands, launches all workers on one batch, waits for completion, then drains every worker's colour buffer to the framebuffer write port in pixel order. It sits between the frame controller (frame_start, sphere) and the N_WORKERS worker instances plus the framebuffer.

Parameters:
N_WORKERS, 4, number of worker instances driven.
JOBS_SUBDIVISION, 8, pixels computed per worker per activation.
SCREEN_W, 320, pixels per row; must be a multiple of N_WORKERS*JOBS_SUBDIVISION.
SCREEN_H, 240, rows per frame.
COLOR_W, 8, width of Types::Color.
ADDR_W, 17, framebuffer address width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
frame_start  in  1  single-cycle pulse; starts a frame when idle
sphere_in  in  Types::Sphere  scene sphere, sampled on the accepted frame_start
frame_busy  out  1  high from the accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse after the last pixel is accepted
worker_activate  out  N_WORKERS  activate line per worker
worker_start_x  out  N_WORKERS*12  signed pixel_start_x per worker
sphere_out  out  Types::Sphere  latched sphere broadcast to all workers
doty_r  out  22 signed  y*sphere.y for the current row
pixely_sr  out  16  y*y for the current row
originy_sr  out  27  sphere.y*sphere.y
worker_busy  in  N_WORKERS  busy line per worker
worker_buffer  in  N_WORKERS*JOBS_SUBDIVISION*COLOR_W  buffer per worker, job 0 in the LSBs
fb_wr_en  out  1  write request
fb_addr  out  ADDR_W  row*SCREEN_W + column
fb_data  out  COLOR_W  pixel colour
fb_ready  in  1  framebuffer accepts the write this cycle

Behaviour:
- Reset: all outputs 0, including activate, frame_busy, frame_done, fb_wr_en, every operand and sphere_out. State IDLE; row and batch counters 0. Reset mid-frame aborts immediately; the frame is not resumed.
- B = N_WORKERS*JOBS_SUBDIVISION pixels per batch; SCREEN_W/B batches per row.
- Coordinates: row r maps to y = r - SCREEN_H/2. Batch k of worker w gets worker_start_x[w] = -SCREEN_W/2 + k*B + w. Worker w job j covers column k*B + j*N_WORKERS + w.
- IDLE: frame_start latches sphere_in into sphere_out, sets frame_busy, clears row, goes to ROW_SETUP. frame_start is ignored in every other state.
- ROW_SETUP (1 cycle): register doty_r, pixely_sr and originy_sr using full-precision signed products truncated to the port widths. Clear batch. Go to LAUNCH. The operands stay stable for the whole row.
- LAUNCH (1 cycle): drive worker_start_x and raise all worker_activate bits. Go to WAIT_ACK.
- WAIT_ACK: hold activate until worker_busy is all ones, then go to WAIT_DONE. This prevents a false done on the cycle before workers assert busy.
- WAIT_DONE: hold activate until worker_busy is all zeros. Workers then sit in FINISHED with their buffers stable. Go to DRAIN with pixel index p = 0.
- DRAIN: activate stays high.
  - fb_wr_en = 1; fb_data = worker_buffer[w = p mod N_WORKERS][j = p / N_WORKERS]; fb_addr = r*SCREEN_W + k*B + p.
  - Address and data are held stable until fb_wr_en && fb_ready. On acceptance p increments; the next write can follow in the next cycle, so throughput is 1 pixel/cycle when fb_ready stays high.
  - After p = B-1 is accepted: fb_wr_en drops and state goes to GAP.
- GAP (1 cycle): all activate low, which resets the workers to READY. Next state:
  - another batch in the row: k+1 and LAUNCH;
  - else another row: r+1 and ROW_SETUP;
  - else DONE.
- DONE (1 cycle): frame_done = 1, frame_busy = 0, go to IDLE. A frame_start on this cycle is ignored.
- Total latency per batch = 2 + worker time + B (with fb_ready held high) + 1 cycles.

Test Plan:
- Params N=2, J=2, W=8, H=2; workers modelled with busy high for 5 cycles and buffer[w][j] = 16*w + j; fb_ready = 1. Pulse frame_start -> exactly 16 writes at addr 0..15; addr 1 has data 16, addr 2 has data 1; frame_done exactly once; frame_busy high throughout.
- Row operands with sphere.y = -3, row 0 (y = -1) -> doty_r = 3, pixely_sr = 1, originy_sr = 9; row 1 (y = 0) -> doty_r = 0, pixely_sr = 0.
- Start x values: batch 1 of row 0 -> worker_start_x = {-4+4+0, -4+4+1} = {0, 1}; activate is low for exactly 1 cycle between batches.
- fb_ready toggling 1/0 each cycle during DRAIN -> no write lost or duplicated; addr and data held while ready is low; still 16 unique addresses.
- Worker busy delayed 3 cycles after activate -> the scheduler stays in WAIT_ACK, no DRAIN starts early, and writes are correct.
- Assert rst during DRAIN of batch 1 -> all outputs 0 on the next edge; a new frame_start restarts the frame at addr 0; frame_start pulsed while busy is ignored.
